// File: rtl/scratchpad_writeback_pkg.sv
// scratchpad_writeback_pkg: FSM encoding, slot-select width and element-count helper for the writeback stage
package scratchpad_writeback_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam int SEL_W = 2;
  function automatic int elem_count(input int max_dim);
    return max_dim * max_dim;
  endfunction
endpackage

// File: rtl/scratchpad_writeback_acc_adder.sv
// wb_acc_adder: accumulate adder, wrap-around by default, signed-saturating when WRITEBACK_ACC_SAT_EN is defined
module wb_acc_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  logic [W-1:0] raw;
  assign raw = a + b;
`ifdef WRITEBACK_ACC_SAT_EN
  logic ovf;
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
  assign sum = ovf ? {a[W-1], {(W-1){~a[W-1]}}} : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/scratchpad_writeback.sv
// scratchpad_writeback: streams a captured result matrix into one scratchpad slot, optional read-modify-write accumulate (saturating under WRITEBACK_ACC_SAT_EN)
module scratchpad_writeback
  import scratchpad_writeback_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int MAX_DIM     = 4,
  parameter int ELEMENT_NUM = 1,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 start_i,
  input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] res_flat_i,
  input  logic [1:0]                           rows_i,
  input  logic [1:0]                           cols_i,
  input  logic [SEL_W-1:0]                     slot_i,
  input  logic                                 acc_i,
  input  logic [BUS_WIDTH-1:0]                 sp_rdata_i,
  output logic [ADDR_WIDTH-1:0]                sp_addr_o,
  output logic [BUS_WIDTH-1:0]                 sp_din_o,
  output logic                                 sp_ien_o,
  output logic [SEL_W-1:0]                     sp_write_sel_o,
  output logic [SEL_W-1:0]                     sp_bus_sel_o,
  output logic                                 busy_o,
  output logic                                 done_o
);
  localparam int N = elem_count(MAX_DIM);
  if (N > 2 ** ADDR_WIDTH || ELEMENT_NUM < 1 || ELEMENT_NUM > 2 ** SEL_W) begin : g_bad_cfg
    $error("scratchpad_writeback: address space or slot count does not fit the configuration");
  end
  logic [1:0]            state;
  logic [BUS_WIDTH-1:0]  res_q [N];
  logic [1:0]            rows_q, cols_q, row, col;
  logic [SEL_W-1:0]      slot_q;
  logic                  acc_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [BUS_WIDTH-1:0]  word, acc_sum;
  logic                  last;
  assign idx  = ADDR_WIDTH'(row) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(col);
  assign word = res_q[idx];
  assign last = (row == rows_q) && (col == cols_q);
  wb_acc_adder #(.W(BUS_WIDTH)) u_add (
    .a(sp_rdata_i),
    .b(word),
    .sum(acc_sum)
  );
  // Capture the job on start, then walk the valid window row-major one word per cycle
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      state  <= ST_IDLE;
      rows_q <= '0;
      cols_q <= '0;
      slot_q <= '0;
      acc_q  <= 1'b0;
      row    <= '0;
      col    <= '0;
      res_q  <= '{default: '0};
    end else if (state == ST_IDLE) begin
      if (start_i) begin
        state  <= ST_WRITE;
        rows_q <= rows_i;
        cols_q <= cols_i;
        slot_q <= slot_i;
        acc_q  <= acc_i;
        row    <= '0;
        col    <= '0;
        for (int i = 0; i < N; i++) res_q[i] <= res_flat_i[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end else if (state == ST_WRITE) begin
      state <= last ? ST_DONE : ST_WRITE;
      col   <= (col == cols_q) ? '0 : col + 1'b1;
      row   <= (col == cols_q) ? row + 1'b1 : row;
    end else begin
      state <= ST_IDLE;
    end
  // Write port is combinational from state so element_out reflects the addressed word this cycle
  always_comb begin
    sp_ien_o       = state == ST_WRITE;
    sp_addr_o      = sp_ien_o ? idx : '0;
    sp_din_o       = !sp_ien_o ? '0 : acc_q ? acc_sum : word;
    sp_write_sel_o = sp_ien_o ? slot_q : '0;
    sp_bus_sel_o   = sp_write_sel_o;
    busy_o         = sp_ien_o;
    done_o         = state == ST_DONE;
  end
endmodule

// File: tb/tb_scratchpad_writeback.sv
// tb_scratchpad_writeback: randomized self-checking bench with a scratchpad memory and a matrix-level reference model
module tb_scratchpad_writeback;
  localparam int BW = 32, MD = 4, NE = 1, AW = 4, N = MD * MD;
  logic clk = 0, rst_n = 0, start = 0, acc = 0;
  logic [BW*N-1:0] res_flat = '0;
  logic [1:0] rows = 0, cols = 0, slot = 0;
  logic [BW-1:0] sp_rdata, sp_din;
  logic [AW-1:0] sp_addr;
  logic sp_ien, busy, done;
  logic [1:0] sp_write_sel, sp_bus_sel;
  logic [BW-1:0] sp [4][N] = '{default: '0};
  logic [BW-1:0] mdl [N];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  scratchpad_writeback #(.BUS_WIDTH(BW), .MAX_DIM(MD), .ELEMENT_NUM(NE), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .res_flat_i(res_flat),
    .rows_i(rows), .cols_i(cols), .slot_i(slot), .acc_i(acc), .sp_rdata_i(sp_rdata),
    .sp_addr_o(sp_addr), .sp_din_o(sp_din), .sp_ien_o(sp_ien), .sp_write_sel_o(sp_write_sel),
    .sp_bus_sel_o(sp_bus_sel), .busy_o(busy), .done_o(done)
  );
  assign sp_rdata = sp[sp_bus_sel][sp_addr];
  always @(posedge clk) if (sp_ien && sp_write_sel < NE) sp[sp_write_sel][sp_addr] <= sp_din;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
`ifdef WRITEBACK_ACC_SAT_EN
    longint s;
    s = longint'(signed'(a)) + longint'(signed'(b));
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
    return s[31:0];
`else
    return a + b;
`endif
  endfunction
  function automatic logic [BW*N-1:0] fill(input logic [31:0] v);
    logic [BW*N-1:0] m;
    for (int i = 0; i < N; i++) m[i*BW +: BW] = v;
    return m;
  endfunction
  function automatic logic [BW*N-1:0] rnd_mat();
    logic [BW*N-1:0] m;
    for (int i = 0; i < N; i++) m[i*BW +: BW] = $urandom;
    return m;
  endfunction
  function automatic logic [8:0] idle_outs();
    return {sp_ien, busy, done, |sp_addr, |sp_din, sp_write_sel, sp_bus_sel};
  endfunction
  task automatic run_wb(input int r, input int c, input int s, input int a, input logic [BW*N-1:0] m, input int abort_at);
    int exp_addr[$];
    int n, writes, done_at, dones, ix;
    n = (r + 1) * (c + 1);
    writes = 0; done_at = 0; dones = 0;
    for (int i = 0; i <= r; i++) for (int j = 0; j <= c; j++) exp_addr.push_back(i * MD + j);
    rows = 2'(r); cols = 2'(c); slot = 2'(s); acc = a[0]; res_flat = m; start = 1;
    tick;
    start = 0; res_flat = ~m; acc = ~acc; slot = ~slot;
    for (int k = 1; k <= n + 3; k++) begin
      if (sp_ien) begin
        if (writes < n) begin
          ix = exp_addr[writes];
          check("wr_addr", 64'(sp_addr), 64'(ix));
          check("wr_sel", {62'd0, sp_write_sel}, 64'(s));
          check("bus_sel", {62'd0, sp_bus_sel}, 64'(s));
          check("wr_cycle", 64'(k), 64'(writes + 1));
          check("busy_wr", 64'(busy), 64'd1);
          if (s < NE) mdl[ix] = a != 0 ? acc_add(mdl[ix], m[ix*BW +: BW]) : m[ix*BW +: BW];
        end else check("extra_write", 64'd1, 64'd0);
        writes++;
      end
      if (done) begin
        dones++;
        if (done_at == 0) done_at = k;
      end
      if (abort_at != 0 && writes == abort_at) break;
      if (abort_at != 0 && k == 2) begin
        start = 1; rows = 0; cols = 0; res_flat = '0;
      end else start = 0;
      tick;
    end
    start = 0;
    if (abort_at != 0) begin
      rst_n = 0;
      tick;
      check("abort_outs", 64'(idle_outs()), 64'd0);
      tick;
      rst_n = 1;
      for (int k = 0; k < 6; k++) begin
        tick;
        check("post_abort", 64'(idle_outs()), 64'd0);
      end
      check("abort_done", 64'(dones), 64'd0);
    end else begin
      check("writes", 64'(writes), 64'(n));
      check("done_cycle", 64'(done_at), 64'(n + 1));
      check("done_count", 64'(dones), 64'd1);
      check("idle_after", 64'(idle_outs()), 64'd0);
    end
    for (int i = 0; i < N; i++) check("mem", 64'(sp[0][i]), 64'(mdl[i]));
  endtask
  initial begin
    logic [BW*N-1:0] m;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    start = 1; res_flat = rnd_mat(); rows = 3; cols = 3;
    for (int k = 0; k < 10; k++) begin
      tick;
      check("reset_outs", 64'(idle_outs()), 64'd0);
    end
    start = 0; rst_n = 1;
    tick; tick;
    check("idle_outs", 64'(idle_outs()), 64'd0);
    for (int i = 0; i < N; i++) m[i*BW +: BW] = 32'((i / MD) * 16 + i % MD);
    run_wb(3, 3, 0, 0, m, 0);
    check("rc_word", 64'(sp[0][14]), 64'h32);
    for (int i = 0; i < N; i++) m[i*BW +: BW] = 32'hA000 + 32'(i);
    run_wb(1, 2, 0, 0, m, 0);
    check("kept3", 64'(sp[0][3]), 64'h3);
    check("wr6", 64'(sp[0][6]), 64'hA006);
    run_wb(3, 3, 0, 0, fill(100), 0);
    run_wb(3, 3, 0, 1, fill(5), 0);
    check("acc105", 64'(sp[0][9]), 64'd105);
    run_wb(3, 3, 0, 1, fill(5), 0);
    check("acc110", 64'(sp[0][15]), 64'd110);
    run_wb(3, 3, 0, 0, fill(32'h7FFFFFFF), 0);
    run_wb(3, 3, 0, 1, fill(1), 0);
`ifdef WRITEBACK_ACC_SAT_EN
    check("ovf", 64'(sp[0][0]), 64'h7FFFFFFF);
`else
    check("ovf", 64'(sp[0][0]), 64'h80000000);
`endif
    run_wb(0, 0, 0, 0, fill(32'h1234), 0);
    run_wb(0, 0, 2, 0, fill(32'h5678), 0);
    for (int t = 0; t < 12; t++)
      run_wb($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             $urandom_range(0, 1), rnd_mat(), 0);
    run_wb(3, 3, 0, 0, rnd_mat(), 3);
    run_wb(2, 1, 0, 1, rnd_mat(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scratchpad_writeback.md
Name: scratchpad_writeback

Overview:
Downstream-of-compute, upstream-of-scratchpad stage. Captures a flattened MAX_DIM x MAX_DIM result matrix from the matmul engine and writes it into one scratchpad element slot, one word per cycle, over the scratchpad write port (addr/din/ien/element_write_sel). In accumulate mode it performs a same-cycle read-modify-write using the scratchpad's combinational element_out path, so C += A*B needs no extra buffer.

Parameters:
BUS_WIDTH, 32, width of one matrix element / scratchpad word
MAX_DIM, 4, maximum matrix dimension
ELEMENT_NUM, 1, number of scratchpad matrix slots
ADDR_WIDTH, 4, scratchpad word address width; must satisfy 2^ADDR_WIDTH >= MAX_DIM*MAX_DIM

Ports:
clk_i  input  1  clock
rst_n_i  input  1  synchronous active-low reset
start_i  input  1  one-cycle pulse: capture res_flat_i and begin writeback
res_flat_i  input  BUS_WIDTH*MAX_DIM*MAX_DIM  result matrix, element (r,c) at word index r*MAX_DIM+c
rows_i  input  2  valid rows minus 1 (0..3), sampled on start_i
cols_i  input  2  valid columns minus 1 (0..3), sampled on start_i
slot_i  input  2  target scratchpad slot, sampled on start_i
acc_i  input  1  1 = add result to existing contents, sampled on start_i
sp_rdata_i  input  BUS_WIDTH  scratchpad element_out
sp_addr_o  output  ADDR_WIDTH  scratchpad addr
sp_din_o  output  BUS_WIDTH  scratchpad din
sp_ien_o  output  1  scratchpad ien
sp_write_sel_o  output  2  scratchpad element_write_sel
sp_bus_sel_o  output  2  scratchpad bus_element_sel (equals latched slot while busy)
busy_o  output  1  high from cycle after accepted start through last write
done_o  output  1  one-cycle pulse after last write

Behaviour:
- Reset (rst_n_i=0 at posedge): FSM->IDLE; all outputs 0; capture register and counters cleared. Reset mid-writeback aborts immediately; no further ien, no done_o.
- FSM states: IDLE, WRITE, DONE.
- IDLE: start_i=1 -> latch res_flat_i, rows, cols, slot, acc; row=col=0; -> WRITE. start_i in WRITE/DONE ignored (no re-capture).
- WRITE: each cycle sp_ien_o=1, sp_addr_o=row*MAX_DIM+col, sp_write_sel_o=sp_bus_sel_o=slot; sp_din_o = res word (acc=0) or sp_rdata_i + res word (acc=1), BUS_WIDTH two's-complement, wrap on overflow. Outputs combinational from registered state so sp_rdata_i reflects the addressed word in the same cycle.
- Scan order row-major: col increments; at col==cols wrap col=0, row++. At row==rows && col==cols -> DONE after this write.
- Skipped positions (col>cols or row>rows) never written; untouched words retain contents.
- DONE: done_o=1 for one cycle, ien=0, -> IDLE. Start accepted again the cycle after DONE.
- Latency: start at edge T -> first write at cycle T+1, last write at T+(rows+1)*(cols+1), done_o the following cycle. 1x1: write at T+1, done_o at T+2.
- slot_i >= ELEMENT_NUM: writes still issued (scratchpad ignores them), done_o still pulses.
- busy_o=1 in WRITE, 0 in IDLE/DONE.

Optional Feature:
Macro WRITEBACK_ACC_SAT_EN. Defined: accumulate add is signed-saturating (clamps to max positive / min negative BUS_WIDTH value on overflow); non-accumulate path unchanged. Undefined: wrap-around add as above.

Decomposition:
- Shared package: FSM state encoding (IDLE/WRITE/DONE), slot-select width (2), element-index helper constant MAX_DIM*MAX_DIM.
- One natural sub-module: wb_acc_adder (BUS_WIDTH adder, saturating variant under WRITEBACK_ACC_SAT_EN).

Test Plan:
- Reset then idle: all outputs 0, no ien for 10 cycles, start ignored while rst_n_i=0.
- 4x4 overwrite, slot 0, element (r,c)=r*16+c: 16 consecutive ien cycles addr 0..15, done_o at T+17, scratchpad readback matches.
- 2x3 overwrite (rows=1, cols=2): writes at addr 0,1,2,4,5,6 only; addr 3,7..15 keep prior values; done_o at T+7.
- Accumulate: preload all words 100, result all 5, acc=1 -> every word reads 105; second pass -> 110.
- Overflow: preload 0x7FFFFFFF, result 1, acc=1 -> 0x80000000 without macro, 0x7FFFFFFF with WRITEBACK_ACC_SAT_EN.
- Start pulse during WRITE and rst_n_i low at 3rd write: second start ignored; after reset no ien, no done_o, busy_o=0.
